// File: rtl/peaks_sequencer_if.sv
// Handshake/control bundle between the peaks sequencer and the detector/frame source.
// The master modport is the sequencer; slave is the surrounding datapath.
interface peaks_sequencer_if #(
    parameter int TW = 16
);
    logic          frame_avail;
    logic          frame_ack;
    logic          flush;
    logic          pk_strobe;
    logic          pk_zero;
    logic          pk_clear;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_time;
    logic          done;
    logic          busy;

    modport master (
        input  frame_avail, flush, out_ready,
        output frame_ack, pk_strobe, pk_zero, pk_clear, out_valid, out_time, done, busy
    );

    modport slave (
        output frame_avail, flush, out_ready,
        input  frame_ack, pk_strobe, pk_zero, pk_clear, out_valid, out_time, done, busy
    );
endinterface

// File: rtl/peaks_sequencer.sv
// Sequences FFT frames into a 3-tap peak detector: strobe, wait, present result, drain on flush.
// All outputs registered; OUT holds until out_ready, new frames wait in IDLE.
module peaks_sequencer #(
    parameter int HI_CYC = 2,
    parameter int LO_CYC = 2,
    parameter int TW     = 16
) (
    input  logic               clk,
    input  logic               reset,
    peaks_sequencer_if.master  bus
);
    localparam int MAXC = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, HI, LO, OUT, CLR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] fcnt_q;
    logic [TW-1:0] out_time_q;
    logic [1:0]    zcnt_q;
    logic [1:0]    strobes_q;
    logic          flush_pend_q;
    logic          pk_strobe_q;
    logic          pk_zero_q;
    logic          pk_clear_q;
    logic          frame_ack_q;
    logic          out_valid_q;
    logic          done_q;
    logic          busy_q;

    logic          flush_pend_d;
    logic          hi_last;
    logic          lo_last;

    // A flush arriving this cycle is visible to the IDLE decision immediately.
    assign flush_pend_d = flush_pend_q | bus.flush;
    assign hi_last      = (cnt_q == CW'(HI_CYC - 1));
    assign lo_last      = (cnt_q == CW'(LO_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fcnt_q       <= '0;
            out_time_q   <= '0;
            zcnt_q       <= '0;
            strobes_q    <= '0;
            flush_pend_q <= 1'b0;
            pk_strobe_q  <= 1'b0;
            pk_zero_q    <= 1'b0;
            pk_clear_q   <= 1'b0;
            frame_ack_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pk_clear_q   <= 1'b0;
            done_q       <= 1'b0;
            frame_ack_q  <= 1'b0;
            flush_pend_q <= flush_pend_d;
            case (state_q)
                IDLE: begin
                    if (bus.frame_avail) begin
                        state_q     <= HI;
                        cnt_q       <= '0;
                        pk_strobe_q <= 1'b1;
                        pk_zero_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        frame_ack_q <= (HI_CYC == 1);
                    end else if (flush_pend_d) begin
                        busy_q <= 1'b1;
                        // Two zero frames push the last real frames through the 3-tap window.
                        if (zcnt_q < 2'd2 && fcnt_q != '0) begin
                            state_q     <= HI;
                            cnt_q       <= '0;
                            pk_strobe_q <= 1'b1;
                            pk_zero_q   <= 1'b1;
                        end else begin
                            state_q    <= CLR;
                            pk_clear_q <= 1'b1;
                            done_q     <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (hi_last) begin
                        state_q     <= LO;
                        cnt_q       <= '0;
                        pk_strobe_q <= 1'b0;
                        fcnt_q      <= fcnt_q + 1'b1;
                        if (pk_zero_q) zcnt_q <= zcnt_q + 1'b1;
                        if (strobes_q != 2'd3) strobes_q <= strobes_q + 1'b1;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        frame_ack_q <= (cnt_q == CW'(HI_CYC - 2)) && !pk_zero_q;
                    end
                end
                LO: begin
                    if (lo_last) begin
                        if (strobes_q == 2'd3) begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                            // Detector centre tap lags the newest strobe by two frames.
                            out_time_q  <= fcnt_q - TW'(3);
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                CLR: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    pk_zero_q    <= 1'b0;
                    fcnt_q       <= '0;
                    zcnt_q       <= '0;
                    strobes_q    <= '0;
                    flush_pend_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pk_strobe = pk_strobe_q;
    assign bus.pk_zero   = pk_zero_q;
    assign bus.pk_clear  = pk_clear_q;
    assign bus.frame_ack = frame_ack_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_time  = out_time_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule
